// File: rtl/i2c_clk_cmd_sender_pkg.sv
// Shared types and default bytes for the clock-generator command sender.
// Command codes, FSM states and the default I2C address/data bytes live here.
package i2c_clk_cmd_sender_pkg;

  typedef enum logic {
    CMD_SLOW = 1'b0,
    CMD_FAST = 1'b1
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BITS  = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h70;
  localparam logic [7:0] DEF_REG_ADDR   = 8'hCD;
  localparam logic [7:0] DEF_SLOW_DATA  = 8'h4E;
  localparam logic [7:0] DEF_FAST_DATA  = 8'h0E;

  localparam logic [1:0] LAST_BYTE = 2'd2;
  localparam logic [2:0] LAST_BIT  = 3'd7;

  function automatic logic [7:0] cmdData(input cmd_e cmd,
                                         input logic [7:0] slowData,
                                         input logic [7:0] fastData);
    return (cmd == CMD_SLOW) ? slowData : fastData;
  endfunction

endpackage

// File: rtl/i2c_clk_cmd_sender_qtr_tick.sv
// Quarter-SCL-period divider: counts 0..QTR_DIV-1 while enabled and pulses
// tick_o for one clk on the wrap; a synchronous clear restarts a full period.
module i2c_qtr_tick #(
  parameter int unsigned QTR_DIV = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (QTR_DIV > 2) ? $clog2(QTR_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(QTR_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_clk_cmd_sender.sv
// Turns edges of the POST-counter request level into SLOWDOWN/SPEEDUP I2C
// write frames to the clock generator, driving open-drain SCL/SDA enables.
module i2c_clk_cmd_sender
  import i2c_clk_cmd_sender_pkg::*;
#(
  parameter int unsigned QTR_DIV    = 25,
  parameter logic [6:0]  SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter logic [7:0]  REG_ADDR   = DEF_REG_ADDR,
  parameter logic [7:0]  SLOW_DATA  = DEF_SLOW_DATA,
  parameter logic [7:0]  FAST_DATA  = DEF_FAST_DATA
) (
  input  logic clk,
  input  logic reset,
  input  logic i2c_send,
  input  logic sda_in,
  output logic scl_oe,
  output logic sda_oe,
  output logic busy,
  output logic done,
  output logic nack
);

  logic   sendS1_q, sendS2_q, sendPrev_q;
  logic   sdaS1_q, sdaS2_q;
  logic   riseEdge, fallEdge;

  logic   pendValid_q, pendValid_d;
  cmd_e   pendCmd_q, pendCmd_d;
  cmd_e   frameCmd_q, frameCmd_d;

  state_e state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [1:0] byteCnt_q, byteCnt_d;
  logic [7:0] shift_q, shift_d;
  logic       nack_q, nack_d;
  logic       done_q, done_d;

  logic startFrame;
  logic tick;

  // Both async inputs pass through two flops; the third send flop gives the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sendS1_q   <= 1'b0;
      sendS2_q   <= 1'b0;
      sendPrev_q <= 1'b0;
      sdaS1_q    <= 1'b0;
      sdaS2_q    <= 1'b0;
    end else begin
      sendS1_q   <= i2c_send;
      sendS2_q   <= sendS1_q;
      sendPrev_q <= sendS2_q;
      sdaS1_q    <= sda_in;
      sdaS2_q    <= sdaS1_q;
    end
  end

  assign riseEdge   = sendS2_q & ~sendPrev_q;
  assign fallEdge   = ~sendS2_q & sendPrev_q;
  assign startFrame = (state_q == ST_IDLE) && pendValid_q;

  i2c_qtr_tick #(
    .QTR_DIV(QTR_DIV)
  ) u_qtr_tick (
    .clk   (clk),
    .reset (reset),
    .en_i  (state_q != ST_IDLE),
    .clr_i (startFrame),
    .tick_o(tick)
  );

  // A new edge wins over the pop in the same clk, so the newest request is never lost.
  always_comb begin
    pendValid_d = pendValid_q;
    pendCmd_d   = pendCmd_q;
    if (startFrame) begin
      pendValid_d = 1'b0;
    end
    if (riseEdge) begin
      pendValid_d = 1'b1;
      pendCmd_d   = CMD_SLOW;
    end else if (fallEdge) begin
      pendValid_d = 1'b1;
      pendCmd_d   = CMD_FAST;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pendValid_q <= 1'b0;
      pendCmd_q   <= CMD_SLOW;
      frameCmd_q  <= CMD_SLOW;
      qtr_q       <= 2'd0;
      bitCnt_q    <= 3'd0;
      byteCnt_q   <= 2'd0;
      shift_q     <= 8'd0;
      nack_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pendValid_q <= pendValid_d;
      pendCmd_q   <= pendCmd_d;
      frameCmd_q  <= frameCmd_d;
      qtr_q       <= qtr_d;
      bitCnt_q    <= bitCnt_d;
      byteCnt_q   <= byteCnt_d;
      shift_q     <= shift_d;
      nack_q      <= nack_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pendValid_q) state_d = ST_START;
      end
      ST_START: begin
        if (tick && qtr_q == 2'd1) state_d = ST_BITS;
      end
      ST_BITS: begin
        if (tick && qtr_q == 2'd3 && bitCnt_q == LAST_BIT) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (tick && qtr_q == 2'd3) begin
          state_d = (byteCnt_q == LAST_BYTE) ? ST_STOP : ST_BITS;
        end
      end
      ST_STOP: begin
        if (tick && qtr_q == 2'd2) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Quarter, bit and byte counters advance on ticks; qtr restarts on every state change.
  always_comb begin
    qtr_d      = qtr_q;
    bitCnt_d   = bitCnt_q;
    byteCnt_d  = byteCnt_q;
    shift_d    = shift_q;
    nack_d     = nack_q;
    frameCmd_d = frameCmd_q;
    done_d     = 1'b0;

    if (startFrame) begin
      qtr_d      = 2'd0;
      bitCnt_d   = 3'd0;
      byteCnt_d  = 2'd0;
      shift_d    = {SLAVE_ADDR, 1'b0};
      nack_d     = 1'b0;
      frameCmd_d = pendCmd_q;
    end else if (tick) begin
      qtr_d = (state_d != state_q) ? 2'd0 : qtr_q + 2'd1;
      case (state_q)
        ST_BITS: begin
          if (qtr_q == 2'd3) begin
            bitCnt_d = bitCnt_q + 3'd1;
            shift_d  = {shift_q[6:0], 1'b0};
          end
        end
        ST_ACK: begin
          if (qtr_q == 2'd2 && sdaS2_q) begin
            nack_d = 1'b1;
          end
          if (qtr_q == 2'd3) begin
            byteCnt_d = byteCnt_q + 2'd1;
            if (byteCnt_q == 2'd0) begin
              shift_d = REG_ADDR;
            end else begin
              shift_d = cmdData(frameCmd_q, SLOW_DATA, FAST_DATA);
            end
          end
        end
        ST_STOP: begin
          if (qtr_q == 2'd2) done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pad enables: SDA only moves while SCL is held low, except in START and STOP.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      ST_START: begin
        sda_oe = (qtr_q == 2'd1);
      end
      ST_BITS: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_oe = ~shift_q[7];
      end
      ST_ACK: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
      end
      ST_STOP: begin
        scl_oe = (qtr_q == 2'd0);
        sda_oe = (qtr_q != 2'd2);
      end
      default: ;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign nack = nack_q;

endmodule

// File: tb/tb_i2c_clk_cmd_sender.sv
// Scoreboard bench: an I2C slave model decodes each frame off the pull-up bus
// and compares it with frames predicted from the request edges.
module tb_i2c_clk_cmd_sender;

  localparam int unsigned QTR = 2;

  logic clk = 1'b0;
  logic reset;
  logic i2c_send;
  logic sda_in;
  logic scl_oe, sda_oe, busy, done, nack;
  logic slaveRel = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic       nack;
  } frame_t;

  frame_t expQ[$];
  int checks = 0;
  int passes = 0;
  int doneCount = 0;
  logic modelBusy = 1'b0;
  logic modelPendValid = 1'b0;
  logic [7:0] modelPendData = 8'h00;
  logic nackAddr = 1'b0;

  logic prevScl, prevSda, curScl, curSda, prevDone;
  logic inFrame;
  logic expectBusyNext;
  int bitIdx, byteCount, sdaViol;
  logic [7:0] curByte;
  logic [7:0] bytes [3];

  assign sda_in = ~sda_oe & slaveRel;

  always #5 clk = ~clk;

  i2c_clk_cmd_sender #(
    .QTR_DIV(QTR)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i2c_send(i2c_send),
    .sda_in  (sda_in),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .done    (done),
    .nack    (nack)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Reference: one frame in flight, one newest-wins pending request behind it.
  task automatic modelEdge(input logic rise);
    frame_t f;
    f.data = rise ? 8'h4E : 8'h0E;
    f.nack = nackAddr;
    if (!modelBusy) begin
      expQ.push_back(f);
      modelBusy = 1'b1;
    end else begin
      modelPendValid = 1'b1;
      modelPendData  = f.data;
    end
  endtask

  task automatic applyStimulus(input logic level);
    @(posedge clk);
    #1;
    if (level !== i2c_send) modelEdge(level);
    i2c_send = level;
  endtask

  task automatic waitIdle();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (!modelBusy && !busy && expQ.size() == 0) break;
    end
    if (i == 3000) begin
      checks++;
      $display("[TB] FAIL waitIdle timeout: busy=%0b queued=%0d expected idle", busy, expQ.size());
    end
    repeat (5) @(posedge clk);
  endtask

  task automatic flushModel();
    expQ.delete();
    modelBusy      = 1'b0;
    modelPendValid = 1'b0;
  endtask

  // Slave side: decode bits on SCL rise, ACK/NACK in the 9th clock, check frame at done.
  always @(negedge clk) begin
    frame_t e;
    frame_t nf;
    curScl = ~scl_oe;
    curSda = sda_in;
    if (reset) begin
      prevScl = 1'b1;
      prevSda = 1'b1;
      prevDone = 1'b0;
      slaveRel = 1'b1;
      inFrame = 1'b0;
      expectBusyNext = 1'b0;
      bitIdx = 0;
      byteCount = 0;
      sdaViol = 0;
    end else begin
      if (prevScl && curScl && (prevSda !== curSda)) begin
        if (!curSda && !inFrame) begin
          inFrame = 1'b1;
          bitIdx = 0;
          byteCount = 0;
          sdaViol = 0;
          curByte = 8'h00;
        end else if (curSda && inFrame && byteCount == 3) begin
          inFrame = 1'b0;
        end else begin
          sdaViol++;
        end
      end
      if (!prevScl && curScl && inFrame && byteCount < 3) begin
        if (bitIdx < 8) begin
          curByte = {curByte[6:0], curSda};
          bitIdx++;
        end else begin
          bytes[byteCount] = curByte;
          byteCount++;
          bitIdx = 0;
        end
      end
      if (prevScl && !curScl && inFrame) begin
        slaveRel = (bitIdx == 8) ? (nackAddr && byteCount == 0) : 1'b1;
      end

      if (done) begin
        doneCount++;
        checkOutput("done single pulse", {31'd0, prevDone}, 32'd0);
        checkOutput("busy low at done", {31'd0, busy}, 32'd0);
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected frame: got done with empty queue, expected none");
        end else begin
          e = expQ.pop_front();
          checkOutput("byte count", byteCount, 3);
          checkOutput("addr byte", {24'd0, bytes[0]}, 32'hE0);
          checkOutput("reg byte", {24'd0, bytes[1]}, 32'hCD);
          checkOutput("data byte", {24'd0, bytes[2]}, {24'd0, e.data});
          checkOutput("nack at done", {31'd0, nack}, {31'd0, e.nack});
          checkOutput("sda while scl high", sdaViol, 0);
          checkOutput("stop seen", {31'd0, inFrame}, 32'd0);
        end
        if (modelPendValid) begin
          nf.data = modelPendData;
          nf.nack = nackAddr;
          expQ.push_back(nf);
          modelPendValid = 1'b0;
          expectBusyNext = 1'b1;
        end else begin
          modelBusy = 1'b0;
        end
      end else if (expectBusyNext) begin
        checkOutput("back-to-back start", {31'd0, busy}, 32'd1);
        expectBusyNext = 1'b0;
      end
      prevDone = done;
      prevScl = curScl;
      prevSda = curSda;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int saved;
    int n;
    reset = 1'b1;
    i2c_send = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset scl_oe", {31'd0, scl_oe}, 32'd0);
    checkOutput("reset sda_oe", {31'd0, sda_oe}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset nack", {31'd0, nack}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Reset held mid-frame aborts it with no done pulse.
    applyStimulus(1'b1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checkOutput("busy mid-frame", {31'd0, busy}, 32'd1);
    saved = doneCount;
    @(posedge clk);
    #1;
    reset = 1'b1;
    i2c_send = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort scl_oe", {31'd0, scl_oe}, 32'd0);
    checkOutput("abort sda_oe", {31'd0, sda_oe}, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    flushModel();
    repeat (300) @(posedge clk);
    @(negedge clk);
    checkOutput("no done across reset", doneCount, saved);
    checkOutput("idle after reset", {31'd0, busy}, 32'd0);

    // SLOWDOWN, SPEEDUP, then NACK on address followed by a clean frame.
    applyStimulus(1'b1);
    waitIdle();
    applyStimulus(1'b0);
    waitIdle();
    nackAddr = 1'b1;
    applyStimulus(1'b1);
    waitIdle();
    nackAddr = 1'b0;
    applyStimulus(1'b0);
    waitIdle();

    // Rise then fall inside one frame: two frames back-to-back.
    applyStimulus(1'b1);
    repeat (40) @(posedge clk);
    applyStimulus(1'b0);
    waitIdle();

    // Rise, fall, rise inside one frame: newest (SLOW) request wins.
    applyStimulus(1'b1);
    repeat (30) @(posedge clk);
    applyStimulus(1'b0);
    repeat (30) @(posedge clk);
    applyStimulus(1'b1);
    waitIdle();

    for (int r = 0; r < 6; r++) begin
      nackAddr = 1'($urandom_range(0, 1));
      applyStimulus(~i2c_send);
      n = $urandom_range(0, 3);
      repeat (n) begin
        repeat ($urandom_range(15, 45)) @(posedge clk);
        applyStimulus(~i2c_send);
      end
      waitIdle();
    end

    checkOutput("frames all consumed", expQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
